// File: rtl/fir_frame_ctrl.sv
// Frame controller wrapping an external FIR: clears the filter, feeds one frame of samples,
// flushes the tail and tags outputs. Optional macro: FIR_FRAME_CTRL_UNDERRUN_CNT_EN.
module fir_frame_ctrl #(
  parameter int PIPE_LAT  = 14,
  parameter int NTAPS     = 10,
  parameter int CLEAR_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] frame_len,
  input  logic        s_valid,
  input  logic [16:0] s_data,
  output logic        s_ready,
  output logic [16:0] f_in,
  output logic        f_clk_enable,
  output logic        f_reset,
  input  logic [16:0] f_out,
  output logic        m_valid,
  output logic [16:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam int          DATA_W   = 17;
  localparam logic [15:0] CLR_LAST = 16'(CLEAR_CYC - 1);
  localparam logic [15:0] FL_LAST  = 16'(NTAPS - 2);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DRAIN} state_t;

  state_t              state, state_n;
  logic [15:0]         cnt, cnt_n;
  logic [15:0]         len_q;
  logic                issue, issue_last;
  logic [PIPE_LAT:0]   tag_vld, tag_last;
  logic [1:0]          rst_sync;
  logic                rst_n;
  logic                frame_start;
  logic                zero_start;

  // Reset asserts immediately but is released only after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign frame_start = (state == IDLE) && start && (frame_len != 16'd0);
  assign zero_start  = (state == IDLE) && start && (frame_len == 16'd0);

  assign s_ready      = (state == RUN);
  assign f_clk_enable = (state != IDLE);
  assign busy         = (state != IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_n = CLEAR;
          cnt_n   = 16'd0;
        end
      end
      CLEAR: begin
        if (cnt == CLR_LAST) begin
          state_n = RUN;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (cnt == len_q - 16'd1) begin
          issue_last = (NTAPS == 1);
          state_n    = (NTAPS == 1) ? DRAIN : FLUSH;
          cnt_n      = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      FLUSH: begin
        issue = 1'b1;
        if (cnt == FL_LAST) begin
          issue_last = 1'b1;
          state_n    = DRAIN;
          cnt_n      = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DRAIN: begin
        if (tag_last[PIPE_LAT]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control: state, slot counter, tag pipeline (tag at index PIPE_LAT lines up with f_out).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      len_q    <= 16'd0;
      tag_vld  <= '0;
      tag_last <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      f_reset  <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tag_vld[0]  <= issue;
      tag_last[0] <= issue_last;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      m_valid <= tag_vld[PIPE_LAT];
      m_last  <= tag_last[PIPE_LAT];
      done    <= zero_start || ((state == DRAIN) && tag_last[PIPE_LAT]);
      f_reset <= (state_n == CLEAR);
      if (frame_start) begin
        len_q    <= frame_len;
        underrun <= 1'b0;
      end else if ((state == RUN) && !s_valid) begin
        underrun <= 1'b1;
      end
    end
  end

  // Data stage p0: filter input; p1: captured filter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_in   <= '0;
      m_data <= '0;
    end else begin
      if ((state == RUN) && s_valid) f_in <= s_data[DATA_W-1:0];
      else                           f_in <= '0;
      if (tag_vld[PIPE_LAT]) m_data <= f_out;
    end
  end

`ifdef FIR_FRAME_CTRL_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        urun_cnt <= 16'd0;
    else if (frame_start)              urun_cnt <= 16'd0;
    else if ((state == RUN) && !s_valid) urun_cnt <= sat_inc(urun_cnt);
  end
  assign underrun_cnt = urun_cnt;
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Scoreboard bench for fir_frame_ctrl with a behavioural FIR standing in for the filter.
module tb_fir_frame_ctrl;
  localparam int PIPE_LAT  = 14;
  localparam int NTAPS     = 10;
  localparam int CLEAR_CYC = 2;
  localparam int COEF [NTAPS] = '{16, 8, 4, 2, 1, -1, -2, -4, -8, -16};
  localparam logic [16:0] IMP [NTAPS] = '{17'h0FFFF, 17'h07FFF, 17'h03FFF, 17'h01FFF, 17'h00FFF,
                                          17'h1F000, 17'h1E000, 17'h1C000, 17'h18000, 17'h10001};

  logic        clk, reset, start, s_valid, s_ready, f_clk_enable, f_reset;
  logic        m_valid, m_last, busy, done, underrun;
  logic [15:0] frame_len, underrun_cnt;
  logic [16:0] s_data, f_in, f_out, m_data;

  fir_frame_ctrl #(.PIPE_LAT(PIPE_LAT), .NTAPS(NTAPS), .CLEAR_CYC(CLEAR_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .f_in(f_in),
    .f_clk_enable(f_clk_enable), .f_reset(f_reset), .f_out(f_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural filter: FIR on f_in, result delayed PIPE_LAT cycles, sync clear on f_reset.
  logic signed [16:0] hist [NTAPS-1];
  logic [16:0]        ypipe [PIPE_LAT];
  always @(posedge clk) begin
    longint acc;
    if (f_clk_enable) begin
      if (f_reset) begin
        for (int i = 0; i < NTAPS-1; i++) hist[i] <= '0;
        for (int i = 0; i < PIPE_LAT; i++) ypipe[i] <= '0;
      end else begin
        acc = longint'($signed(f_in)) * COEF[0];
        for (int k = 1; k < NTAPS; k++) acc += longint'(hist[k-1]) * COEF[k];
        hist[0] <= $signed(f_in);
        for (int i = 1; i < NTAPS-1; i++) hist[i] <= hist[i-1];
        ypipe[0] <= 17'(acc >>> 4);
        for (int i = 1; i < PIPE_LAT; i++) ypipe[i] <= ypipe[i-1];
      end
    end
  end
  assign f_out = ypipe[PIPE_LAT-1];

  typedef struct packed { logic [16:0] data; logic last; } exp_t;
  exp_t   sb[$];
  longint stream[$];
  int vectors = 0, miscompares = 0;
  int out_total = 0, done_total = 0, freset_cyc = 0;
  int o0, d0, f0, acc_cyc, first_mv, exp_miss;
  bit in_frame = 0;

  function automatic logic [16:0] gen(input int i);
    logic [31:0] v;
    v = i * 32'd40503 + 32'd12345;
    return v[16:0];
  endfunction

  function automatic logic [16:0] ref_y(input int n);
    longint acc = 0;
    for (int k = 0; k < NTAPS; k++)
      if (n - k >= 0 && n - k < stream.size()) acc += stream[n-k] * COEF[k];
    return 17'(acc >>> 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_and_feed(input int len, input int ma, input int mb, input int collide, input bit imp);
    logic [16:0] sv;
    logic [16:0] sq[$];
    bit          vq[$];
    exp_t        e;
    int          idx, g, tot;
    stream.delete();
    exp_miss = 0;
    for (int i = 0; i < len; i++) begin
      sv = imp ? 17'h0FFFF : gen(i);
      sq.push_back(sv);
      vq.push_back(!(i == ma || i == mb));
      if (!vq[i]) exp_miss++;
      stream.push_back(vq[i] ? longint'($signed(sv)) : 64'sd0);
    end
    for (int i = 0; i < NTAPS-1; i++) stream.push_back(64'sd0);
    tot = len + NTAPS - 1;
    for (int n = 0; n < tot; n++) begin
      e.data = (imp && n < NTAPS) ? IMP[n] : ref_y(n);
      e.last = (n == tot - 1);
      sb.push_back(e);
    end
    o0 = out_total; d0 = done_total; f0 = freset_cyc;
    start = 1'b1; frame_len = 16'(len);
    tick();
    start = 1'b0;
    idx = 0; g = 0;
    while (idx < len && g < len + 50) begin
      s_valid = 1'b0;
      if (s_ready) begin
        s_valid = vq[idx];
        s_data  = sq[idx];
        if (idx == 0) acc_cyc = cyc + 1;
        if (idx == collide) begin start = 1'b1; frame_len = 16'd5; end
        idx++;
      end
      tick();
      start = 1'b0;
      g++;
    end
    s_valid = 1'b0;
    chk("slots_accepted", idx, len);
  endtask

  task automatic finish_frame(input int len);
    int g = 0;
    while (!done && g < 300) begin tick(); g++; end
    chk("done_pulse", done, 1);
    chk("underrun", underrun, (exp_miss > 0));
`ifdef FIR_FRAME_CTRL_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, exp_miss);
`else
    chk("underrun_cnt", underrun_cnt, 0);
`endif
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    repeat (2) tick();
    chk("out_count", out_total - o0, len + NTAPS - 1);
    chk("done_count", done_total - d0, 1);
    chk("f_reset_cycles", freset_cyc - f0, CLEAR_CYC);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; frame_len = '0; s_valid = 1'b0; s_data = '0;
    first_mv = -1;
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!reset) begin
            in_frame = 0;
          end else begin
            if (m_valid) begin
              out_total++;
              if (first_mv < 0) first_mv = cyc;
              if (sb.size() == 0) begin
                chk("m_valid_unexpected", m_valid, 0);
              end else begin
                e = sb.pop_front();
                chk("m_data", m_data, e.data);
                chk("m_last", m_last, e.last);
                if (m_last) chk("done_with_last", done, 1);
              end
              in_frame = !m_last;
            end else if (in_frame) begin
              chk("m_valid_gap", m_valid, 1);
              in_frame = 0;
            end
            if (done) done_total++;
            if (f_reset && f_clk_enable) freset_cyc++;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_f_in", f_in, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_f_clk_enable", f_clk_enable, 0);
    chk("rst_f_reset", f_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_underrun_cnt", underrun_cnt, 0);
    reset = 1'b1;
    repeat (4) tick();

    // Impulse
    first_mv = -1;
    start_and_feed(1, -1, -1, -1, 1'b1);
    finish_frame(1);
    chk("impulse_latency", first_mv - acc_cyc, PIPE_LAT + 1);

    // Streaming
    start_and_feed(100, -1, -1, -1, 1'b0);
    finish_frame(100);

    // Starvation on slots 3 and 5
    start_and_feed(8, 3, 5, -1, 1'b0);
    finish_frame(8);

    // Zero length
    o0 = out_total; d0 = done_total;
    start = 1'b1; frame_len = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    repeat (20) tick();
    chk("zero_out_count", out_total - o0, 0);
    chk("zero_done_count", done_total - d0, 1);

    // Start collision during RUN
    start_and_feed(20, -1, -1, 7, 1'b0);
    finish_frame(20);

    // Reset during FLUSH
    start_and_feed(10, -1, -1, -1, 1'b0);
    begin
      int g = 0;
      while (!m_valid && g < 40) begin tick(); g++; end
    end
    chk("pre_reset_m_valid", m_valid, 1);
    chk("pre_reset_flush", s_ready, 0);
    reset = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_f_reset", f_reset, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_f_clk_enable", f_clk_enable, 0);
    sb.delete();
    d0 = done_total;
    repeat (3) tick();
    reset = 1'b1;
    repeat (25) tick();
    chk("midrst_no_done", done_total - d0, 0);
    start_and_feed(4, -1, -1, -1, 1'b0);
    finish_frame(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
